// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and data access.
// Optional build macro ARB_TIMEOUT_EN adds a busy-state watchdog that aborts hung accesses and sets bus_err.

module unified_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        stall_f,
    output logic        stall_m,
    output logic        bus_err,

    output logic [2:0]  dbg_state
);

    // Handshake: a requester raises x_req with stable address/data and holds it until the
    // single-cycle x_ack; x_rdata is valid in the ack cycle. Toward memory, mem_req and its
    // fields stay constant until the cycle mem_ready=1, which completes the access.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_RESP_I = 3'd3,
        S_RESP_D = 3'd4
    } state_t;

    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t      state_q,     state_d;
    logic        last_grant_q, last_grant_d;
    logic        mem_req_q,   mem_req_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q,    if_ack_d;
    logic        dm_ack_q,    dm_ack_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] dm_rdata_q,  dm_rdata_d;
    logic        bus_err_q,   bus_err_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        dm_ack_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        bus_err_d    = bus_err_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Data wins when it is the only requester or when fetch went last.
                if (dm_req && (!if_req || last_grant_q == GRANT_F)) begin
                    state_d      = S_BUSY_D;
                    last_grant_d = GRANT_D;
                    mem_req_d    = 1'b1;
                    mem_we_d     = dm_we;
                    mem_addr_d   = dm_addr;
                    mem_wdata_d  = dm_wdata;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end else if (if_req) begin
                    state_d      = S_BUSY_I;
                    last_grant_d = GRANT_F;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_wdata_d  = '0;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d    = '0;
`endif
                end
            end

            S_BUSY_I: begin
                if (mem_ready) begin
                    state_d    = S_RESP_I;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = S_RESP_I;
                    mem_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = 32'hDEAD_BEEF;
                    bus_err_d  = 1'b1;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 16'd1;
                end
`endif
            end

            S_BUSY_D: begin
                if (mem_ready) begin
                    state_d   = S_RESP_D;
                    mem_req_d = 1'b0;
                    dm_ack_d  = 1'b1;
                    // Stores leave the load-data register untouched.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d    = S_RESP_D;
                    mem_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = 32'hDEAD_BEEF;
                    bus_err_d  = 1'b1;
                end else begin
                    tmo_cnt_d  = tmo_cnt_q + 16'd1;
                end
`endif
            end

            S_RESP_I,
            S_RESP_D: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_F;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            bus_err_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            bus_err_q    <= bus_err_d;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_f   = if_req & ~if_ack_q;
    assign stall_m   = dm_req & ~dm_ack_q;
    assign dbg_state = state_q;

`ifdef ARB_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    logic unused_bus_err;
    assign unused_bus_err = bus_err_q;
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: reset, arbitration order, fetch/load/store timing,
// reset mid-access and (with ARB_TIMEOUT_EN) the watchdog path.

module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_req, mem_we, stall_f, stall_m, bus_err;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_f   (stall_f),
        .stall_m   (stall_m),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

        // Reset values
        cyc(); cyc(); mid();
        chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_ack",    {31'd0, if_ack},  32'd0);
        chk("rst_dm_ack",    {31'd0, dm_ack},  32'd0);
        chk("rst_if_rdata",  if_rdata,  32'd0);
        chk("rst_dm_rdata",  dm_rdata,  32'd0);
        chk("rst_bus_err",   {31'd0, bus_err}, 32'd0);
        chk("rst_state",     {29'd0, dbg_state}, 32'd0);

        // Simultaneous requests after reset: data first, then alternate
        cyc(); rst = 0; if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
        mid();
        chk("both_stall_f", {31'd0, stall_f}, 32'd1);
        chk("both_stall_m", {31'd0, stall_m}, 32'd1);
        chk("both_idle_req", {31'd0, mem_req}, 32'd0);
        cyc(); mem_ready = 1; mem_rdata = 32'h1111_1111; mid();
        chk("g1_mem_req",  {31'd0, mem_req}, 32'd1);
        chk("g1_mem_addr", mem_addr, 32'h200);
        chk("g1_mem_we",   {31'd0, mem_we}, 32'd0);
        cyc(); mem_ready = 0; mid();
        chk("g1_dm_ack",   {31'd0, dm_ack}, 32'd1);
        chk("g1_dm_rdata", dm_rdata, 32'h1111_1111);
        chk("g1_stall_m",  {31'd0, stall_m}, 32'd0);
        chk("g1_stall_f",  {31'd0, stall_f}, 32'd1);
        chk("g1_if_ack",   {31'd0, if_ack}, 32'd0);
        cyc(); mid();
        chk("g1_ack_pulse", {31'd0, dm_ack}, 32'd0);
        chk("g1_idle_req",  {31'd0, mem_req}, 32'd0);
        cyc(); mem_ready = 1; mem_rdata = 32'h2222_2222; mid();
        chk("g2_mem_addr", mem_addr, 32'h80);
        chk("g2_mem_req",  {31'd0, mem_req}, 32'd1);
        cyc(); mem_ready = 0; mid();
        chk("g2_if_ack",   {31'd0, if_ack}, 32'd1);
        chk("g2_if_rdata", if_rdata, 32'h2222_2222);
        chk("g2_dm_hold",  dm_rdata, 32'h1111_1111);
        cyc(); mid();
        cyc(); mem_ready = 1; mem_rdata = 32'h3333_3333; mid();
        chk("g3_mem_addr", mem_addr, 32'h200);
        cyc(); mem_ready = 0; if_req = 0; dm_req = 0; mid();
        chk("g3_dm_ack",   {31'd0, dm_ack}, 32'd1);
        chk("g3_dm_rdata", dm_rdata, 32'h3333_3333);
        cyc(); mid();
        chk("g3_ack_pulse", {31'd0, dm_ack}, 32'd0);

        // Single fetch with one-cycle ready
        cyc(); if_req = 1; if_addr = 32'h40; mid();
        chk("f_stall_n",   {31'd0, stall_f}, 32'd1);
        chk("f_req_n",     {31'd0, mem_req}, 32'd0);
        cyc(); mem_ready = 1; mem_rdata = 32'h0050_0093; mid();
        chk("f_req_n1",    {31'd0, mem_req}, 32'd1);
        chk("f_addr_n1",   mem_addr, 32'h40);
        chk("f_stall_n1",  {31'd0, stall_f}, 32'd1);
        chk("f_ack_n1",    {31'd0, if_ack}, 32'd0);
        cyc(); mem_ready = 0; mid();
        chk("f_ack_n2",    {31'd0, if_ack}, 32'd1);
        chk("f_rdata_n2",  if_rdata, 32'h0050_0093);
        chk("f_stall_n2",  {31'd0, stall_f}, 32'd0);
        cyc(); if_req = 0; mid();
        chk("f_ack_n3",    {31'd0, if_ack}, 32'd0);
        chk("f_state_n3",  {29'd0, dbg_state}, 32'd0);

        // Store with four wait cycles
        cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hCAFE_F00D; mid();
        chk("st_stall", {31'd0, stall_m}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 1) dm_wdata = 32'h0;
            if (i == 4) begin mem_ready = 1; mem_rdata = 32'h9999_9999; end
            mid();
            chk($sformatf("st_req_%0d", i),   {31'd0, mem_req}, 32'd1);
            chk($sformatf("st_we_%0d", i),    {31'd0, mem_we}, 32'd1);
            chk($sformatf("st_addr_%0d", i),  mem_addr, 32'h100);
            chk($sformatf("st_wdata_%0d", i), mem_wdata, 32'hCAFE_F00D);
            chk($sformatf("st_ack_%0d", i),   {31'd0, dm_ack}, 32'd0);
        end
        cyc(); mem_ready = 0; mid();
        chk("st_dm_ack",   {31'd0, dm_ack}, 32'd1);
        chk("st_dm_rdata", dm_rdata, 32'h3333_3333);
        chk("st_mem_req",  {31'd0, mem_req}, 32'd0);
        cyc(); dm_req = 0; dm_we = 0; mid();
        chk("st_ack_pulse", {31'd0, dm_ack}, 32'd0);

        // mem_ready while idle is ignored
        cyc(); mem_ready = 1; mem_rdata = 32'hDEAD_0000; if_req = 1; if_addr = 32'h44; mid();
        chk("rdy_idle_req", {31'd0, mem_req}, 32'd0);
        cyc(); mem_ready = 0; mid();
        chk("rdy_busy1", {31'd0, mem_req}, 32'd1);
        cyc(); mem_ready = 1; mem_rdata = 32'h5555_5555; mid();
        chk("rdy_busy2",  {31'd0, mem_req}, 32'd1);
        chk("rdy_no_ack", {31'd0, if_ack}, 32'd0);
        chk("rdy_hold",   if_rdata, 32'h0050_0093);
        cyc(); mem_ready = 0; mid();
        chk("rdy_ack",    {31'd0, if_ack}, 32'd1);
        chk("rdy_rdata",  if_rdata, 32'h5555_5555);
        cyc(); if_req = 0; mid();

        // Reset during BUSY_D
        cyc(); dm_req = 1; dm_addr = 32'h300; mid();
        cyc(); mid();
        chk("mr_busy_req",   {31'd0, mem_req}, 32'd1);
        chk("mr_busy_state", {29'd0, dbg_state}, 32'd2);
        #1 rst = 1;
        #1;
        chk("mr_req_clear",   {31'd0, mem_req}, 32'd0);
        chk("mr_state_clear", {29'd0, dbg_state}, 32'd0);
        cyc(); rst = 0; dm_req = 0; mid();
        chk("mr_no_ack0", {31'd0, dm_ack}, 32'd0);
        chk("mr_rdata0",  dm_rdata, 32'd0);
        cyc(); dm_req = 1; dm_addr = 32'h304; mid();
        chk("mr_no_ack1", {31'd0, dm_ack}, 32'd0);
        cyc(); mem_ready = 1; mem_rdata = 32'h7777_7777; mid();
        chk("mr_new_req",  {31'd0, mem_req}, 32'd1);
        chk("mr_new_addr", mem_addr, 32'h304);
        cyc(); mem_ready = 0; mid();
        chk("mr_new_ack",   {31'd0, dm_ack}, 32'd1);
        chk("mr_new_rdata", dm_rdata, 32'h7777_7777);
        cyc(); dm_req = 0; mid();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: no ready for 8 busy cycles
        cyc(); if_req = 1; if_addr = 32'h60; mid();
        for (int i = 0; i < 8; i++) begin
            cyc(); mid();
            chk($sformatf("to_req_%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("to_err_%0d", i), {31'd0, bus_err}, 32'd0);
            chk($sformatf("to_ack_%0d", i), {31'd0, if_ack}, 32'd0);
        end
        cyc(); mid();
        chk("to_ack",   {31'd0, if_ack}, 32'd1);
        chk("to_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("to_err",   {31'd0, bus_err}, 32'd1);
        chk("to_req",   {31'd0, mem_req}, 32'd0);
        cyc(); if_req = 0; mid();
        cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h8; mid();
        cyc(); mem_ready = 1; mem_rdata = 32'h1234_5678; mid();
        cyc(); mem_ready = 0; mid();
        chk("to_good_ack",   {31'd0, dm_ack}, 32'd1);
        chk("to_good_rdata", dm_rdata, 32'h1234_5678);
        chk("to_err_sticky", {31'd0, bus_err}, 32'd1);
        cyc(); dm_req = 0; mid();
`else
        // Without the watchdog, BUSY waits as long as needed
        cyc(); if_req = 1; if_addr = 32'h60; mid();
        for (int i = 0; i < 12; i++) begin
            cyc(); mid();
            chk($sformatf("wait_req_%0d", i), {31'd0, mem_req}, 32'd1);
            chk($sformatf("wait_ack_%0d", i), {31'd0, if_ack}, 32'd0);
            chk($sformatf("wait_err_%0d", i), {31'd0, bus_err}, 32'd0);
        end
        cyc(); mem_ready = 1; mem_rdata = 32'h6666_6666; mid();
        cyc(); mem_ready = 0; mid();
        chk("wait_ack",   {31'd0, if_ack}, 32'd1);
        chk("wait_rdata", if_rdata, 32'h6666_6666);
        chk("wait_err",   {31'd0, bus_err}, 32'd0);
        cyc(); if_req = 0; mid();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
